// File: rtl/mtimer_tlul.sv
// Machine timer (64-bit mtime / mtimecmp with prescaler and interrupt) behind a TL-UL register port.
// The minimal tlul_pkg it depends on is declared first in this file.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;
endpackage

module mtimer_tlul #(
  parameter int AW = 8,
  parameter int PW = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              intr_timer_o
);
  import tlul_pkg::*;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      else       res[8*i +: 8] = old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic          ctrl_en_q, ctrl_en_d;
  logic [PW-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic          intr_state_q, intr_state_d, intr_en_q, intr_en_d, intr_timer_q, intr_timer_d;
  logic          d_valid_q, d_valid_d, d_error_q, d_error_d;
  logic [2:0]    d_opcode_q, d_opcode_d;
  logic [1:0]    d_size_q, d_size_d;
  logic [7:0]    d_source_q, d_source_d;
  logic [31:0]   d_data_q, d_data_d;

  logic          accept_s, is_get_s, is_put_s, err_s, wr_s, tick_s, set_s, w1c_s;
  logic [2:0]    idx_s;
  logic [31:0]   rdata_s, presc_wr_s;
  logic          unused_s;

  assign unused_s = ^{tl_i.a_param, tl_i.a_address[31:AW]};

  // Request decode, tick/compare conditions and read mux (all from registered state)
  always_comb begin
    accept_s = tl_i.a_valid && !d_valid_q;
    is_get_s = (tl_i.a_opcode == Get);
    is_put_s = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    err_s    = !(is_get_s || is_put_s) || (tl_i.a_address[1:0] != 2'b00) ||
               (tl_i.a_address[AW-1:5] != {(AW-5){1'b0}});
    wr_s     = accept_s && is_put_s && !err_s;
    idx_s    = tl_i.a_address[4:2];
    tick_s   = ctrl_en_q && (pcnt_q == prescale_q);
    set_s    = ctrl_en_q && (mtime_q >= mtimecmp_q);
    w1c_s    = wr_s && (idx_s == 3'd6) && tl_i.a_mask[0] && tl_i.a_data[0];
    case (idx_s)
      3'd0:    rdata_s = {31'd0, ctrl_en_q};
      3'd1:    rdata_s = {{(32-PW){1'b0}}, prescale_q};
      3'd2:    rdata_s = mtime_q[31:0];
      3'd3:    rdata_s = mtime_q[63:32];
      3'd4:    rdata_s = mtimecmp_q[31:0];
      3'd5:    rdata_s = mtimecmp_q[63:32];
      3'd6:    rdata_s = {31'd0, intr_state_q};
      3'd7:    rdata_s = {31'd0, intr_en_q};
      default: rdata_s = 32'd0;
    endcase
  end

  // Next-state: counters, register writes, interrupt and response channel
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    prescale_d = prescale_q;
    mtimecmp_d = mtimecmp_q;
    intr_en_d  = intr_en_q;
    presc_wr_s = byte_merge({{(32-PW){1'b0}}, prescale_q}, tl_i.a_data, tl_i.a_mask);
    if (ctrl_en_q) begin
      if (tick_s) begin
        pcnt_d  = {PW{1'b0}};
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d  = pcnt_q + {{(PW-1){1'b0}}, 1'b1};
        mtime_d = mtime_q;
      end
    end else begin
      pcnt_d  = pcnt_q;
      mtime_d = mtime_q;
    end
    // A software write to either mtime half pre-empts that cycle's tick on both halves
    if (wr_s) begin
      case (idx_s)
        3'd0: ctrl_en_d = tl_i.a_mask[0] ? tl_i.a_data[0] : ctrl_en_q;
        3'd1: prescale_d = presc_wr_s[PW-1:0];
        3'd2: mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], tl_i.a_data, tl_i.a_mask)};
        3'd3: mtime_d = {byte_merge(mtime_q[63:32], tl_i.a_data, tl_i.a_mask), mtime_q[31:0]};
        3'd4: mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], tl_i.a_data, tl_i.a_mask);
        3'd5: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], tl_i.a_data, tl_i.a_mask);
        3'd7: intr_en_d = tl_i.a_mask[0] ? tl_i.a_data[0] : intr_en_q;
        default: ctrl_en_d = ctrl_en_q;
      endcase
    end else begin
      ctrl_en_d = ctrl_en_q;
    end
    if (set_s)      intr_state_d = 1'b1;
    else if (w1c_s) intr_state_d = 1'b0;
    else            intr_state_d = intr_state_q;
    intr_timer_d = intr_state_q && intr_en_q;

    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    if (accept_s) begin
      d_valid_d  = 1'b1;
      d_opcode_d = is_get_s ? AccessAckData : AccessAck;
      d_size_d   = tl_i.a_size;
      d_source_d = tl_i.a_source;
      d_data_d   = (is_get_s && !err_s) ? rdata_s : 32'd0;
      d_error_d  = err_s;
    end else if (d_valid_q && tl_i.d_ready) begin
      d_valid_d = 1'b0;
    end else begin
      d_valid_d = d_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en_q    <= 1'b0;
      prescale_q   <= {PW{1'b0}};
      pcnt_q       <= {PW{1'b0}};
      mtime_q      <= 64'd0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      intr_state_q <= 1'b0;
      intr_en_q    <= 1'b0;
      intr_timer_q <= 1'b0;
      d_valid_q    <= 1'b0;
      d_opcode_q   <= 3'd0;
      d_size_q     <= 2'd0;
      d_source_q   <= 8'd0;
      d_data_q     <= 32'd0;
      d_error_q    <= 1'b0;
    end else begin
      ctrl_en_q    <= ctrl_en_d;
      prescale_q   <= prescale_d;
      pcnt_q       <= pcnt_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      intr_state_q <= intr_state_d;
      intr_en_q    <= intr_en_d;
      intr_timer_q <= intr_timer_d;
      d_valid_q    <= d_valid_d;
      d_opcode_q   <= d_opcode_d;
      d_size_q     <= d_size_d;
      d_source_q   <= d_source_d;
      d_data_q     <= d_data_d;
      d_error_q    <= d_error_d;
    end
  end

  // Response channel drive
  always_comb begin
    tl_o          = {$bits(tl_d2h_t){1'b0}};
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = !d_valid_q;
  end

  assign intr_timer_o = intr_timer_q;
endmodule

// File: tb/tb_mtimer_tlul.sv
// Randomized + directed bench for mtimer_tlul, checked every cycle against a behavioural model.
module tb_mtimer_tlul;
  import tlul_pkg::*;
  localparam int PW = 12;

  logic    clk = 1'b0;
  logic    rst_ni;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic    intr;

  always #5 clk = ~clk;

  mtimer_tlul #(.AW(8), .PW(PW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o), .intr_timer_o(intr)
  );

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit          m_en, m_is, m_ie, m_irq;
  bit [PW-1:0] m_presc, m_pcnt;
  bit [63:0]   m_mtime, m_cmp;
  bit          m_dv, m_derr, last_acc;
  bit [2:0]    m_dop;
  bit [31:0]   m_dd;
  bit [7:0]    m_dsrc;
  bit [1:0]    m_dsz;

  bit [31:0] rd;
  bit        er;
  bit        got;
  bit [31:0] v0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_presc = '0; m_pcnt = '0; m_mtime = 64'd0; m_cmp = {64{1'b1}};
    m_is = 0; m_ie = 0; m_irq = 0; m_dv = 0; m_derr = 0; m_dop = 0; m_dd = 0;
    m_dsrc = 0; m_dsz = 0;
  endtask

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] m);
    bit [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = m[i/8] ? n[i] : o[i];
    return r;
  endfunction

  function automatic bit [31:0] mrd(input bit [7:0] off);
    case (off)
      8'h00: return {31'd0, m_en};
      8'h04: return 32'(m_presc);
      8'h08: return m_mtime[31:0];
      8'h0C: return m_mtime[63:32];
      8'h10: return m_cmp[31:0];
      8'h14: return m_cmp[63:32];
      8'h18: return {31'd0, m_is};
      8'h1C: return {31'd0, m_ie};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: predict from current model + inputs, advance, then compare the DUT
  task automatic step();
    bit acc, err, is_get, is_put, wr, tick, setc, w1c;
    bit [7:0] off;
    bit [31:0] wd, tmp, rdv;
    bit [3:0] mk;
    bit n_en, n_ie, n_is, n_irq;
    bit [PW-1:0] n_presc, n_pcnt;
    bit [63:0] n_mt, n_cmp;
    acc    = tl_i.a_valid && !m_dv;
    off    = tl_i.a_address[7:0];
    is_get = tl_i.a_opcode == 3'd4;
    is_put = tl_i.a_opcode == 3'd0 || tl_i.a_opcode == 3'd1;
    err    = !(is_get || is_put) || off[1:0] != 2'd0 || off >= 8'h20 || tl_i.a_address[31:8] != 0;
    wr     = acc && is_put && !err;
    wd     = tl_i.a_data;
    mk     = tl_i.a_mask;
    tick   = m_en && (m_pcnt == m_presc);
    setc   = m_en && (m_mtime >= m_cmp);
    rdv    = mrd(off);
    n_en = m_en; n_presc = m_presc; n_cmp = m_cmp; n_ie = m_ie; w1c = 0;
    n_pcnt = !m_en ? m_pcnt : (tick ? '0 : m_pcnt + 1'b1);
    n_mt   = m_mtime + (tick ? 64'd1 : 64'd0);
    if (wr) begin
      case (off)
        8'h00: if (mk[0]) n_en = wd[0];
        8'h04: begin tmp = merge(32'(m_presc), wd, mk); n_presc = tmp[PW-1:0]; end
        8'h08: n_mt = {m_mtime[63:32], merge(m_mtime[31:0], wd, mk)};
        8'h0C: n_mt = {merge(m_mtime[63:32], wd, mk), m_mtime[31:0]};
        8'h10: n_cmp[31:0] = merge(m_cmp[31:0], wd, mk);
        8'h14: n_cmp[63:32] = merge(m_cmp[63:32], wd, mk);
        8'h18: w1c = mk[0] && wd[0];
        8'h1C: if (mk[0]) n_ie = wd[0];
        default: ;
      endcase
    end
    n_is  = setc ? 1'b1 : (w1c ? 1'b0 : m_is);
    n_irq = m_is && m_ie;
    @(posedge clk);
    #1;
    if (acc) begin
      m_dv = 1; m_dop = is_get ? 3'd1 : 3'd0; m_derr = err;
      m_dd = (is_get && !err) ? rdv : 32'd0;
      m_dsrc = tl_i.a_source; m_dsz = tl_i.a_size;
    end else if (m_dv && tl_i.d_ready) begin
      m_dv = 0;
    end
    m_en = n_en; m_presc = n_presc; m_pcnt = n_pcnt; m_mtime = n_mt; m_cmp = n_cmp;
    m_ie = n_ie; m_is = n_is; m_irq = n_irq; last_acc = acc;
    chk("d_valid", tl_o.d_valid, m_dv);
    chk("a_ready", tl_o.a_ready, !m_dv);
    chk("intr_timer_o", intr, m_irq);
    if (m_dv) begin
      chk("d_opcode", tl_o.d_opcode, m_dop);
      chk("d_data", tl_o.d_data, m_dd);
      chk("d_error", tl_o.d_error, m_derr);
      chk("d_source", tl_o.d_source, m_dsrc);
      chk("d_size", tl_o.d_size, m_dsz);
    end
  endtask

  task automatic xact(input bit [2:0] op, input bit [31:0] addr, input bit [31:0] data,
                      input bit [3:0] mask, output bit [31:0] rdat, output bit rerr);
    int n = 0;
    tl_i.a_valid = 1; tl_i.a_opcode = op; tl_i.a_address = addr; tl_i.a_data = data;
    tl_i.a_mask = mask; tl_i.a_size = 2'd2; tl_i.a_source = 8'($urandom); tl_i.d_ready = 1;
    last_acc = 0;
    while (!last_acc && n < 20) begin step(); n++; end
    if (!last_acc) chk("xact_accept_timeout", 0, 1);
    tl_i.a_valid = 0;
    rdat = tl_o.d_data; rerr = tl_o.d_error;
    step();
  endtask

  task automatic wr32(input bit [31:0] addr, input bit [31:0] data);
    bit [31:0] r; bit e;
    xact(3'd0, addr, data, 4'hF, r, e);
  endtask

  task automatic rd32(input bit [31:0] addr, output bit [31:0] data);
    bit e;
    xact(3'd4, addr, 32'd0, 4'hF, data, e);
  endtask

  task automatic do_reset();
    rst_ni = 0;
    tl_i = '0; tl_i.d_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_valid", tl_o.d_valid, 0);
    chk("rst_a_ready", tl_o.a_ready, 1);
    chk("rst_intr", intr, 0);
    rst_ni = 1;
  endtask

  initial begin
    do_reset();
    rd32(32'h10, rd); chk("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    rd32(32'h08, rd); chk("rst_mtime_lo", rd, 32'd0);

    // prescale tick
    wr32(32'h04, 32'd3); wr32(32'h00, 32'd1);
    repeat (40) step();
    rd32(32'h08, rd); chk("s1_mtime_lo", rd, 32'd10);
    rd32(32'h0C, rd); chk("s1_mtime_hi", rd, 32'd0);

    // compare interrupt
    do_reset();
    wr32(32'h14, 32'd0); wr32(32'h10, 32'd5); wr32(32'h1C, 32'd1); wr32(32'h00, 32'd1);
    got = intr;
    for (int i = 2; i <= 7 && !got; i++) begin step(); got = intr; end
    chk("s2_irq_rise", got, 1);
    wr32(32'h18, 32'd1); chk("s2_w1c_held", intr, 1);
    rd32(32'h18, rd); chk("s2_state_held", rd, 32'd1);
    wr32(32'h14, 32'hFFFF_FFFF); wr32(32'h18, 32'd1); chk("s2_irq_clear", intr, 0);

    // wrap
    do_reset();
    wr32(32'h0C, 32'hFFFF_FFFF); wr32(32'h08, 32'hFFFF_FFFE); wr32(32'h04, 32'd0);
    wr32(32'h00, 32'd1); wr32(32'h00, 32'd0);
    rd32(32'h08, rd); chk("s3_lo", rd, 32'd0);
    rd32(32'h0C, rd); chk("s3_hi", rd, 32'd0);

    // errors
    do_reset();
    xact(3'd4, 32'h24, 32'd0, 4'hF, rd, er); chk("s4_get24_err", er, 1); chk("s4_get24_data", rd, 0);
    xact(3'd0, 32'h02, 32'd1, 4'hF, rd, er); chk("s4_put02_err", er, 1);
    rd32(32'h00, rd); chk("s4_ctrl_unchanged", rd, 32'd0);
    xact(3'd2, 32'h00, 32'd1, 4'hF, rd, er); chk("s4_op2_err", er, 1);

    // backpressure
    tl_i.a_valid = 1; tl_i.a_opcode = 3'd4; tl_i.a_address = 32'h10; tl_i.a_mask = 4'hF;
    tl_i.a_source = 8'h5A; tl_i.a_size = 2'd2; tl_i.d_ready = 0;
    step(); tl_i.a_valid = 0;
    v0 = tl_o.d_data; chk("s5_data", v0, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s5_hold_valid", tl_o.d_valid, 1); chk("s5_hold_data", tl_o.d_data, v0);
      chk("s5_hold_ready", tl_o.a_ready, 0);
    end
    tl_i.d_ready = 1; step(); chk("s5_drop", tl_o.d_valid, 0);
    repeat (3) step();

    // partial write
    xact(3'd1, 32'h10, 32'h0000_AB00, 4'b0010, rd, er);
    rd32(32'h10, rd); chk("s6_partial", rd, 32'hFFFF_ABFF);

    // reset with a pending response
    tl_i.a_valid = 1; tl_i.a_opcode = 3'd4; tl_i.a_address = 32'h00; tl_i.d_ready = 0;
    step(); tl_i.a_valid = 0;
    rst_ni = 0; #1;
    chk("s7_rst_dv", tl_o.d_valid, 0);
    model_reset(); tl_i = '0; tl_i.d_ready = 1;
    @(posedge clk); #1; rst_ni = 1;
    repeat (4) step();
    chk("s7_no_resp", tl_o.d_valid, 0);

    // randomized traffic
    wr32(32'h14, 32'd0); wr32(32'h10, 32'd40); wr32(32'h1C, 32'd1); wr32(32'h00, 32'd1);
    for (int c = 0; c < 3000; c++) begin
      int idx;
      idx = $urandom_range(0, 7);
      tl_i.a_valid = $urandom_range(0, 1);
      tl_i.a_address = 32'(idx * 4);
      if ($urandom_range(0, 15) == 0) tl_i.a_address = 32'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0: tl_i.a_opcode = 3'($urandom);
        1, 2, 3: tl_i.a_opcode = 3'd4;
        4, 5: tl_i.a_opcode = 3'd1;
        default: tl_i.a_opcode = 3'd0;
      endcase
      tl_i.a_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      case (idx)
        0: tl_i.a_data = 32'($urandom_range(0, 3) != 0);
        1: tl_i.a_data = 32'($urandom_range(0, 3));
        2, 4: tl_i.a_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom_range(0, 200));
        3, 5: tl_i.a_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'd0;
        default: tl_i.a_data = $urandom;
      endcase
      tl_i.a_source = 8'($urandom);
      tl_i.a_size = 2'($urandom);
      tl_i.d_ready = $urandom_range(0, 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
